// File: rtl/spr_dma_master.sv
// spr_dma_master: sprite OAM DMA bus initiator; optional parity alignment cycle under SPR_DMA_ALIGN_EN
module spr_dma_master #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int          LEN       = 256
) (
  input  logic        clk,
  input  logic        b_rst,
  input  logic        snoop_wen,
  input  logic [15:0] snoop_addr,
  input  logic [7:0]  snoop_data,
  output logic        halt_req,
  input  logic        halt_ack,
  output logic        bus_own,
  output logic        dma_ren,
  output logic        dma_wen,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  input  logic [7:0]  dma_data_in,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, REQ, DUMMY, ALIGN, READ, WRITE, DONE} state_t;
`ifdef SPR_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  state_t state, nxt;
  logic [7:0] page, idx;
  logic cyc_par, trig, last;
  assign trig = snoop_wen && snoop_addr == TRIG_ADDR;
  assign last = idx == 8'(LEN - 1);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = trig ? REQ : IDLE;
      REQ:     nxt = halt_ack ? DUMMY : REQ;
      DUMMY:   nxt = ALIGN_EN && cyc_par ? ALIGN : READ;
      ALIGN:   nxt = READ;
      READ:    nxt = WRITE;
      WRITE:   nxt = last ? DONE : READ;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state <= IDLE;
      page <= '0;
      idx <= '0;
      cyc_par <= 1'b0;
      halt_req <= 1'b0;
      bus_own <= 1'b0;
      dma_ren <= 1'b0;
      dma_wen <= 1'b0;
      dma_addr <= '0;
      dma_data_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cyc_par <= ~cyc_par;
      if (state == IDLE && trig) begin
        page <= snoop_data;
        idx <= '0;
      end
      if (state == WRITE && !last) idx <= idx + 8'd1;
      halt_req <= nxt inside {REQ, DUMMY, ALIGN, READ, WRITE};
      bus_own <= nxt inside {DUMMY, ALIGN, READ, WRITE};
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      dma_ren <= nxt == READ;
      dma_wen <= nxt == WRITE;
      dma_addr <= nxt == READ ? {page, state == WRITE ? idx + 8'd1 : idx} :
                  nxt == WRITE ? DEST_ADDR : 16'h0000;
      dma_data_out <= state == READ ? dma_data_in : 8'h00;
    end
  end
  a_ack_held: assert property (@(posedge clk) disable iff (!b_rst) bus_own |-> halt_ack)
    else $error("halt_ack dropped while DMA owns the bus");
endmodule

// File: tb/tb_spr_dma_master.sv
// tb_spr_dma_master: scoreboard bench for spr_dma_master (reads, writes, ack-to-done latency)
module tb_spr_dma_master;
  logic clk = 0, b_rst = 0, snoop_wen = 0, halt_ack = 0;
  logic [15:0] snoop_addr = 0;
  logic [7:0] snoop_data = 0;
  logic halt_req, bus_own, dma_ren, dma_wen, busy, done;
  logic [15:0] dma_addr;
  logic [7:0] dma_data_out, dma_data_in;
  logic [7:0] mem [0:65535];
  logic [15:0] rd_q [$];
  logic [7:0] wr_q [$];
  int lat_q [$];
  int cyc, ack_cyc, wr_cnt, n_tests, n_fail;
`ifdef SPR_DMA_ALIGN_EN
  localparam int AL = 1;
`else
  localparam int AL = 0;
`endif

  spr_dma_master dut (
    .clk(clk), .b_rst(b_rst), .snoop_wen(snoop_wen), .snoop_addr(snoop_addr),
    .snoop_data(snoop_data), .halt_req(halt_req), .halt_ack(halt_ack), .bus_own(bus_own),
    .dma_ren(dma_ren), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_data_out(dma_data_out),
    .dma_data_in(dma_data_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign dma_data_in = dma_ren ? mem[dma_addr] : 8'h00;

  always @(posedge clk or negedge b_rst)
    if (!b_rst) cyc <= 0;
    else cyc <= cyc + 1;

  // RAM page $02 holds i^$5A, ROM ($8000+) holds i*7+$11, other RAM holds lo+hi
  function automatic logic [7:0] img(input logic [15:0] a);
    logic [7:0] lo, hi;
    lo = a[7:0];
    hi = a[15:8];
    if (a[15]) return 8'(lo * 8'd7 + 8'h11);
    if (hi == 8'h02) return lo ^ 8'h5A;
    return 8'(lo + hi);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (halt_req && halt_ack && !bus_own) ack_cyc = cyc + 1;
    if (dma_ren || dma_wen) begin
      chk("strobe_needs_own", int'(bus_own), 1);
      chk("ren_wen_exclusive", int'(dma_ren & dma_wen), 0);
    end
    if (!dma_wen) chk("data_idle_zero", int'(dma_data_out), 0);
    if (!dma_ren && !dma_wen) chk("addr_idle_zero", int'(dma_addr), 0);
    if (dma_ren) begin
      chk("read_expected", int'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) chk("read_addr", int'(dma_addr), int'(rd_q.pop_front()));
    end
    if (dma_wen) begin
      wr_cnt++;
      chk("write_addr", int'(dma_addr), 16'h2004);
      chk("write_expected", int'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) chk("write_data", int'(dma_data_out), int'(wr_q.pop_front()));
    end
    if (done) begin
      chk("done_busy", int'(busy), 1);
      chk("done_halt_req", int'(halt_req), 0);
      chk("done_expected", int'(lat_q.size() > 0), 1);
      if (lat_q.size() > 0) chk("ack_to_done", cyc - ack_cyc, lat_q.pop_front());
    end
  end

  task automatic trigger(input logic [7:0] p);
    @(negedge clk);
    snoop_wen = 1;
    snoop_addr = 16'h4014;
    snoop_data = p;
    @(negedge clk);
    snoop_wen = 0;
    snoop_addr = 0;
    snoop_data = 0;
  endtask

  task automatic start(input logic [7:0] p);
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({p, 8'(i)});
      wr_q.push_back(img({p, 8'(i)}));
    end
    trigger(p);
  endtask

  // par: required cyc_par while in DUMMY, or -1 for don't-care
  task automatic ack_at(input int delay, input int par);
    repeat (delay) @(negedge clk);
    if (par >= 0) while (((cyc + 1) & 1) != par) @(negedge clk);
    lat_q.push_back(513 + AL * ((cyc + 1) & 1));
    halt_ack = 1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", int'(done), 1);
    halt_ack = 0;
    @(negedge clk);
    chk("busy_cleared", int'(busy), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("write_count_reached", int'(wr_cnt >= n), 1);
  endtask

  initial begin
    int n, k, viol, base;
    for (int a = 0; a < 65536; a++) mem[a] = img(16'(a));
    #1 chk("reset_outputs", int'({halt_req, bus_own, dma_ren, dma_wen, busy, done, dma_addr, dma_data_out}), 0);
    repeat (3) @(negedge clk);
    b_rst = 1;
    @(negedge clk);
    chk("idle_outputs", int'({halt_req, bus_own, busy, done}), 0);
    // 1: page $02 RAM, ack three cycles after trigger
    start(8'h02);
    chk("busy_after_trigger", int'(busy), 1);
    chk("halt_req_after_trigger", int'(halt_req), 1);
    ack_at(3, -1);
    wait_done();
    // 2: ROM page $80
    start(8'h80);
    ack_at(2, -1);
    wait_done();
    // 3: long ack delay, bus must stay released
    start(8'h10);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      viol |= int'(!halt_req || bus_own || dma_ren || dma_wen);
    end
    chk("wait_no_bus", viol, 0);
    k = cyc;
    lat_q.push_back(513 + AL * ((k + 1) & 1));
    halt_ack = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_ren && n < 10);
    chk("ack_to_first_ren", n, 2 + AL * ((k + 1) & 1));
    wait_done();
    // 4: DUMMY on odd then even parity
    start(8'h05);
    ack_at(1, 1);
    wait_done();
    start(8'h05);
    ack_at(1, 0);
    wait_done();
    // 5: retrigger mid-transfer is ignored
    base = wr_cnt;
    start(8'h04);
    ack_at(2, -1);
    wait_wr(base + 10);
    trigger(8'h99);
    wait_done();
    chk("five_write_total", wr_cnt - base, 256);
    // 6: async reset at byte 100, then a fresh transfer from idx 0
    base = wr_cnt;
    start(8'h01);
    ack_at(2, -1);
    wait_wr(base + 100);
    #2 b_rst = 0;
    #1 chk("abort_outputs", int'({halt_req, bus_own, dma_ren, dma_wen, busy, done, dma_addr, dma_data_out}), 0);
    halt_ack = 0;
    rd_q.delete();
    wr_q.delete();
    lat_q.delete();
    repeat (3) @(negedge clk);
    b_rst = 1;
    repeat (3) @(negedge clk);
    chk("post_abort_idle", int'({busy, done, halt_req}), 0);
    start(8'h03);
    ack_at(4, -1);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
